dnn_layer_sequencer: RTL and testbench

- Control FSM for the Milestone 1 DNN datapath. Sequences one inference through NUM_LAYERS layers.
- Per layer: launches the neuron bank, collects per-neuron done pulses, fires a one-cycle ReLU stage enable, then advances the layer index.
- Presents the final result with a valid/ready handshake to downstream logic.
- Sits between the input loader, the neuron bank, the ReLU pipe stage and the output interface.

---
 rtl/dnn_pkg.sv | 23 ++
 rtl/dnn_layer_sequencer_if.sv | 33 +++
 rtl/done_collector.sv | 27 ++
 rtl/dnn_layer_sequencer.sv | 112 +++++++++++
 tb/tb_dnn_layer_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dnn_pkg.sv
// Shared types and defaults for the DNN datapath control slice.
package dnn_pkg;

  localparam int DATA_W          = 12;
  localparam int NUM_LAYERS_DEF  = 3;
  localparam int NUM_NEURONS_DEF = 4;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_N,
    S_RELU,
    S_OUT,
    S_ERR
  } seq_state_t;

  // Layer index width, kept at least one bit for single-layer builds.
  function automatic int lsel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dnn_layer_sequencer_if.sv
// Control bundle between the layer sequencer and the loader/neuron bank/ReLU/output logic.
interface dnn_layer_sequencer_if
  import dnn_pkg::*;
#(
  parameter int NUM_LAYERS  = NUM_LAYERS_DEF,
  parameter int NUM_NEURONS = NUM_NEURONS_DEF
);

  localparam int LSEL_W = lsel_w(NUM_LAYERS);

  logic                   in_valid;
  logic                   in_ready;
  logic                   neuron_start;
  logic [NUM_NEURONS-1:0] neuron_done;
  logic [LSEL_W-1:0]      layer_sel;
  logic                   relu_en;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   timeout_err;
  logic                   err_clr;

  modport master (
    output in_ready, neuron_start, layer_sel, relu_en, out_valid, busy, timeout_err,
    input  in_valid, neuron_done, out_ready, err_clr
  );

  modport slave (
    input  in_ready, neuron_start, layer_sel, relu_en, out_valid, busy, timeout_err,
    output in_valid, neuron_done, out_ready, err_clr
  );

endinterface

// File: rtl/done_collector.sv
// Sticky join of per-neuron done pulses; all_done looks ahead at this cycle's pulses.
module done_collector #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] done,
  output logic         all_done
);

  logic [N-1:0] mask_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_reg <= '0;
    end else if (clr) begin
      mask_reg <= '0;
    end else if (en) begin
      mask_reg <= mask_reg | done;
    end
  end

  assign all_done = &(mask_reg | done);

endmodule

// File: rtl/dnn_layer_sequencer.sv
// Per-inference control FSM: launch layer, join neuron dones, pulse ReLU, hand off result.
module dnn_layer_sequencer
  import dnn_pkg::*;
#(
  parameter int NUM_LAYERS  = NUM_LAYERS_DEF,
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  dnn_layer_sequencer_if.master seq
);

  localparam int LSEL_W = lsel_w(NUM_LAYERS);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [LSEL_W-1:0] LAST_LAYER = LSEL_W'(NUM_LAYERS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

  seq_state_t        state_reg, state_next;
  logic [LSEL_W-1:0] layer_sel_reg, layer_sel_next;
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic              mask_clr, mask_en, all_done;

  done_collector #(.N(NUM_NEURONS)) u_done (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (mask_clr),
    .en       (mask_en),
    .done     (seq.neuron_done),
    .all_done (all_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      layer_sel_reg <= '0;
      tmo_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      layer_sel_reg <= layer_sel_next;
      tmo_cnt_reg   <= tmo_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    layer_sel_next = layer_sel_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    mask_clr       = 1'b0;
    mask_en        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (seq.in_valid) begin
          state_next     = S_START;
          layer_sel_next = '0;
          mask_clr       = 1'b1;
        end
      end
      S_START: begin
        // Dones that race the launch pulse are still captured.
        mask_en      = 1'b1;
        tmo_cnt_next = '0;
        state_next   = S_WAIT_N;
      end
      S_WAIT_N: begin
        mask_en = 1'b1;
        if (all_done) begin
          state_next = S_RELU;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = S_ERR;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      S_RELU: begin
        mask_clr = 1'b1;
        if (layer_sel_reg == LAST_LAYER) begin
          state_next = S_OUT;
        end else begin
          layer_sel_next = layer_sel_reg + 1'b1;
          state_next     = S_START;
        end
      end
      S_OUT: begin
        if (seq.out_ready) begin
          state_next     = S_IDLE;
          layer_sel_next = '0;
        end
      end
      S_ERR: begin
        if (seq.err_clr) begin
          state_next     = S_IDLE;
          layer_sel_next = '0;
          mask_clr       = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Every output is a decode of registered state, so no input reaches an output combinationally.
  assign seq.in_ready     = (state_reg == S_IDLE);
  assign seq.busy         = (state_reg != S_IDLE);
  assign seq.neuron_start = (state_reg == S_START);
  assign seq.relu_en      = (state_reg == S_RELU);
  assign seq.out_valid    = (state_reg == S_OUT);
  assign seq.timeout_err  = (state_reg == S_ERR);
  assign seq.layer_sel    = layer_sel_reg;

endmodule

// File: tb/tb_dnn_layer_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed events/levels, a monitor compares on observation.
module tb_dnn_layer_sequencer;

  localparam int K_START = 0;
  localparam int K_RELU  = 1;
  localparam int K_OUTV  = 2;
  localparam int K_ERR   = 3;

  localparam int L_IN_READY  = 0;
  localparam int L_BUSY      = 1;
  localparam int L_OUT_VALID = 2;
  localparam int L_LAYER     = 3;
  localparam int L_TMO       = 4;
  localparam int L_START     = 5;
  localparam int L_RELU      = 6;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } lvl_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   finish_req = 1'b0;
  bit   mon_done = 1'b0;
  ev_t  ev_q[$];
  lvl_t lvl_q[$];

  dnn_layer_sequencer_if #(.NUM_LAYERS(3), .NUM_NEURONS(4)) ifc ();

  dnn_layer_sequencer #(.NUM_LAYERS(3), .NUM_NEURONS(4), .TIMEOUT_CYC(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_START: return "neuron_start";
      K_RELU:  return "relu_en";
      K_OUTV:  return "out_valid_rise";
      default: return "timeout_err_rise";
    endcase
  endfunction

  function automatic string lname(input int s);
    case (s)
      L_IN_READY:  return "in_ready";
      L_BUSY:      return "busy";
      L_OUT_VALID: return "out_valid";
      L_LAYER:     return "layer_sel";
      L_TMO:       return "timeout_err";
      L_START:     return "neuron_start";
      default:     return "relu_en";
    endcase
  endfunction

  function automatic int sample(input int s);
    case (s)
      L_IN_READY:  return int'(ifc.in_ready);
      L_BUSY:      return int'(ifc.busy);
      L_OUT_VALID: return int'(ifc.out_valid);
      L_LAYER:     return int'(ifc.layer_sel);
      L_TMO:       return int'(ifc.timeout_err);
      L_START:     return int'(ifc.neuron_start);
      default:     return int'(ifc.relu_en);
    endcase
  endfunction

  task automatic exp_ev(input int c, input int k, input int v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    ev_q.push_back(e);
  endtask

  task automatic exp_lvl(input int c, input int s, input int v);
    lvl_t l;
    l.cyc = c; l.sig = s; l.val = v;
    lvl_q.push_back(l);
  endtask

  task automatic match_ev(input int k);
    ev_t e;
    vectors++;
    if (ev_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected %s at cycle %0d (layer_sel=%0d), none expected", kname(k), cyc, ifc.layer_sel);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != int'(ifc.layer_sel)) begin
        miscompares++;
        $display("FAIL event: got %s at cycle %0d layer %0d, expected %s at cycle %0d layer %0d",
                 kname(k), cyc, ifc.layer_sel, kname(e.kind), e.cyc, e.val);
      end else begin
        $display("ok   %s at cycle %0d layer %0d", kname(k), cyc, e.val);
      end
    end
  endtask

  // Monitor: the only process that compares or touches the counters.
  initial begin : monitor
    ev_t  e;
    lvl_t l;
    int   act;
    bit   ov_prev = 1'b0;
    bit   te_prev = 1'b0;
    forever begin
      @(negedge clk);
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        e = ev_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing %s: got none, expected at cycle %0d layer %0d", kname(e.kind), e.cyc, e.val);
      end
      if (ifc.neuron_start) match_ev(K_START);
      if (ifc.relu_en) match_ev(K_RELU);
      if (ifc.out_valid && !ov_prev) match_ev(K_OUTV);
      if (ifc.timeout_err && !te_prev) match_ev(K_ERR);
      ov_prev = ifc.out_valid;
      te_prev = ifc.timeout_err;
      while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
        l = lvl_q.pop_front();
        act = sample(l.sig);
        vectors++;
        if (l.cyc != cyc || act != l.val) begin
          miscompares++;
          $display("FAIL level %s at cycle %0d: got %0d, expected %0d", lname(l.sig), l.cyc, act, l.val);
        end else begin
          $display("ok   %s=%0d at cycle %0d", lname(l.sig), act, cyc);
        end
      end
      if (finish_req && !mon_done) begin
        while (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL never seen %s: got none, expected at cycle %0d", kname(e.kind), e.cyc);
        end
        while (lvl_q.size() > 0) begin
          l = lvl_q.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL unchecked %s: got none, expected %0d at cycle %0d", lname(l.sig), l.val, l.cyc);
        end
        mon_done = 1'b1;
      end
    end
  end

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stimulus
    int t, s, t1;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.neuron_done = '0;
    ifc.out_ready = 1'b0;
    ifc.err_clr = 1'b0;

    // Reset state
    exp_lvl(2, L_IN_READY, 1); exp_lvl(2, L_BUSY, 0); exp_lvl(2, L_OUT_VALID, 0);
    exp_lvl(2, L_LAYER, 0); exp_lvl(2, L_TMO, 0); exp_lvl(2, L_START, 0); exp_lvl(2, L_RELU, 0);
    go_to(3);
    rst_n = 1'b1;

    // Best case: all dones one cycle after each start; out_ready held off five cycles
    go_to(5);
    t = cyc;
    exp_ev(t+1, K_START, 0); exp_ev(t+3, K_RELU, 0);
    exp_ev(t+4, K_START, 1); exp_ev(t+6, K_RELU, 1);
    exp_ev(t+7, K_START, 2); exp_ev(t+9, K_RELU, 2);
    exp_ev(t+10, K_OUTV, 2);
    exp_lvl(t+1, L_BUSY, 1); exp_lvl(t+1, L_IN_READY, 0);
    for (int k = 10; k <= 15; k++) begin
      exp_lvl(t+k, L_OUT_VALID, 1);
      if (k == 14) exp_lvl(t+k, L_IN_READY, 0);
    end
    exp_lvl(t+16, L_IN_READY, 1); exp_lvl(t+16, L_LAYER, 0);
    exp_lvl(t+16, L_OUT_VALID, 0); exp_lvl(t+16, L_BUSY, 0);
    ifc.in_valid = 1'b1;
    go_to(t+1); ifc.in_valid = 1'b0;
    go_to(t+2); ifc.neuron_done = 4'hF; go_to(t+3); ifc.neuron_done = 4'h0;
    go_to(t+5); ifc.neuron_done = 4'hF; go_to(t+6); ifc.neuron_done = 4'h0;
    go_to(t+8); ifc.neuron_done = 4'hF; go_to(t+9); ifc.neuron_done = 4'h0;
    go_to(t+15); ifc.out_ready = 1'b1;
    go_to(t+16); ifc.out_ready = 1'b0;

    // Staggered dones, stray err_clr, dup done in RELU, early out_ready
    go_to(t+18);
    t = cyc; s = t + 1;
    exp_ev(s, K_START, 0); exp_ev(s+10, K_RELU, 0);
    exp_ev(s+11, K_START, 1); exp_ev(s+14, K_RELU, 1);
    exp_ev(s+15, K_START, 2); exp_ev(s+17, K_RELU, 2);
    exp_ev(s+18, K_OUTV, 2);
    exp_lvl(s+5, L_TMO, 0); exp_lvl(s+19, L_IN_READY, 1); exp_lvl(s+19, L_LAYER, 0);
    ifc.in_valid = 1'b1;
    go_to(s);    ifc.in_valid = 1'b0;
    go_to(s+1);  ifc.neuron_done = 4'h1;
    go_to(s+2);  ifc.neuron_done = 4'h8;
    go_to(s+3);  ifc.neuron_done = 4'h1;
    go_to(s+4);  ifc.neuron_done = 4'h0; ifc.err_clr = 1'b1;
    go_to(s+5);  ifc.neuron_done = 4'h2; ifc.err_clr = 1'b0;
    go_to(s+6);  ifc.neuron_done = 4'h1;
    go_to(s+7);  ifc.neuron_done = 4'h0;
    go_to(s+9);  ifc.neuron_done = 4'h4;
    go_to(s+10); ifc.neuron_done = 4'h1; ifc.out_ready = 1'b1;
    go_to(s+11); ifc.neuron_done = 4'h0;
    go_to(s+12); ifc.neuron_done = 4'hE;
    go_to(s+13); ifc.neuron_done = 4'h1;
    go_to(s+14); ifc.neuron_done = 4'h0;
    go_to(s+16); ifc.neuron_done = 4'hF;
    go_to(s+17); ifc.neuron_done = 4'h0;
    go_to(s+19); ifc.out_ready = 1'b0;

    // Timeout: bit3 never arrives
    go_to(s+21);
    t = cyc; s = t + 1;
    exp_ev(s, K_START, 0); exp_ev(s+65, K_ERR, 0);
    exp_lvl(s+64, L_TMO, 0); exp_lvl(s+65, L_TMO, 1);
    exp_lvl(s+69, L_IN_READY, 0); exp_lvl(s+69, L_TMO, 1); exp_lvl(s+69, L_BUSY, 1);
    exp_lvl(s+71, L_TMO, 0); exp_lvl(s+71, L_IN_READY, 1); exp_lvl(s+71, L_LAYER, 0); exp_lvl(s+71, L_BUSY, 0);
    ifc.in_valid = 1'b1;
    go_to(s);    ifc.in_valid = 1'b0;
    go_to(s+1);  ifc.neuron_done = 4'h7;
    go_to(s+2);  ifc.neuron_done = 4'h0;
    go_to(s+66); ifc.in_valid = 1'b1;
    go_to(s+69); ifc.in_valid = 1'b0;
    go_to(s+70); ifc.err_clr = 1'b1;
    go_to(s+71); ifc.err_clr = 1'b0;

    // Final done bit on the timeout edge: completion wins
    go_to(s+73);
    t = cyc; s = t + 1;
    exp_ev(s, K_START, 0); exp_ev(s+65, K_RELU, 0);
    exp_ev(s+66, K_START, 1); exp_ev(s+68, K_RELU, 1);
    exp_ev(s+69, K_START, 2); exp_ev(s+71, K_RELU, 2);
    exp_ev(s+72, K_OUTV, 2);
    exp_lvl(s+65, L_TMO, 0); exp_lvl(s+66, L_TMO, 0); exp_lvl(s+73, L_IN_READY, 1);
    ifc.in_valid = 1'b1;
    go_to(s);    ifc.in_valid = 1'b0;
    go_to(s+1);  ifc.neuron_done = 4'h7;
    go_to(s+2);  ifc.neuron_done = 4'h0;
    go_to(s+64); ifc.neuron_done = 4'h8;
    go_to(s+65); ifc.neuron_done = 4'h0;
    go_to(s+67); ifc.neuron_done = 4'hF;
    go_to(s+68); ifc.neuron_done = 4'h0;
    go_to(s+70); ifc.neuron_done = 4'hF;
    go_to(s+71); ifc.neuron_done = 4'h0;
    go_to(s+72); ifc.out_ready = 1'b1;
    go_to(s+73); ifc.out_ready = 1'b0;

    // Reset mid-WAIT_N of layer 1, then a fresh inference with a done in the START cycle
    go_to(s+75);
    t = cyc; s = t + 1; t1 = s + 7;
    exp_ev(s, K_START, 0); exp_ev(s+2, K_RELU, 0); exp_ev(s+3, K_START, 1);
    exp_lvl(t1, L_IN_READY, 1); exp_lvl(t1, L_BUSY, 0); exp_lvl(t1, L_LAYER, 0);
    exp_lvl(t1, L_START, 0); exp_lvl(t1, L_RELU, 0); exp_lvl(t1, L_OUT_VALID, 0); exp_lvl(t1, L_TMO, 0);
    exp_ev(t1+1, K_START, 0); exp_ev(t1+3, K_RELU, 0);
    exp_ev(t1+4, K_START, 1); exp_ev(t1+6, K_RELU, 1);
    exp_ev(t1+7, K_START, 2); exp_ev(t1+9, K_RELU, 2);
    exp_ev(t1+10, K_OUTV, 2);
    exp_lvl(t1+11, L_IN_READY, 1); exp_lvl(t1+11, L_LAYER, 0);
    ifc.in_valid = 1'b1;
    go_to(s);     ifc.in_valid = 1'b0;
    go_to(s+1);   ifc.neuron_done = 4'hF;
    go_to(s+2);   ifc.neuron_done = 4'h0;
    go_to(s+6);   ifc.neuron_done = 4'hF; rst_n = 1'b0;
    go_to(t1);    ifc.neuron_done = 4'h0; rst_n = 1'b1; ifc.in_valid = 1'b1;
    go_to(t1+1);  ifc.in_valid = 1'b0; ifc.neuron_done = 4'h1;
    go_to(t1+2);  ifc.neuron_done = 4'hE;
    go_to(t1+3);  ifc.neuron_done = 4'h0;
    go_to(t1+5);  ifc.neuron_done = 4'hF;
    go_to(t1+6);  ifc.neuron_done = 4'h0;
    go_to(t1+8);  ifc.neuron_done = 4'hF;
    go_to(t1+9);  ifc.neuron_done = 4'h0;
    go_to(t1+10); ifc.out_ready = 1'b1;
    go_to(t1+11); ifc.out_ready = 1'b0;

    go_to(t1+14);
    finish_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
